dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
- Upstream control stage for the pipelined load-enabled MAC (multiply_acc).
- Accepts a dot-product job: two base addresses plus a vector length.
- Reads operand pairs from two synchronous-read operand memories, streams them into the MAC one pair per cycle, and pulses the MAC load on the first product.
- Captures the MAC accumulator output when the final product has landed and presents it on a valid/ready result port.

Parameters:
- DATA_WIDTH, 16, operand width; must match the MAC's DATA_WIDTH.
- ADDR_WIDTH, 8, operand memory address width.
- LEN_WIDTH, 8, vector length field width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only when busy=0
- len  in  LEN_WIDTH  number of element pairs (0 allowed)
- a_base  in  ADDR_WIDTH  first address in memory A
- b_base  in  ADDR_WIDTH  first address in memory B
- busy  out  1  job in flight or result not yet consumed
- rd_en  out  1  read strobe for both memories
- a_addr  out  ADDR_WIDTH  memory A address
- b_addr  out  ADDR_WIDTH  memory B address
- a_rdata  in  DATA_WIDTH  memory A data, valid 1 cycle after rd_en
- b_rdata  in  DATA_WIDTH  memory B data, valid 1 cycle after rd_en
- mac_a  out  DATA_WIDTH  to MAC a
- mac_b  out  DATA_WIDTH  to MAC b
- mac_load  out  1  to MAC load
- mac_acc  in  DATA_WIDTH  scaled accumulator slice from the MAC
- res_valid  out  1  result available
- res_data  out  DATA_WIDTH  captured result
- res_ready  in  1  result consumer ready

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all flag pipelines cleared; busy, rd_en, mac_load, res_valid = 0; addresses, mac_a, mac_b, res_data = 0.
- Reset mid-job: same as above at the next edge; the partial result is discarded.
- FSM states:
  - IDLE: if start, latch len and bases, go ISSUE (len>0) or ZERO (len=0). busy=1 from the next cycle.
  - ISSUE: rd_en=1 for exactly len consecutive cycles. Addresses run base+k, k=0..len-1, wrapping modulo 2^ADDR_WIDTH. Tag k=0 as "first" and k=len-1 as "last" (len=1 sets both). Go DRAIN after the last issue.
  - DRAIN: wait until the delayed "last" flag fires, then go HOLD.
  - ZERO: res_data<=0, res_valid<=1, go HOLD. No reads, no mac_load.
  - HOLD: res_valid=1 until res_valid&res_ready, then go IDLE with busy=0.
- Operand path: mac_a/mac_b = a_rdata/b_rdata in the cycle after the matching rd_en cycle. Drive 0 when no read data is valid.
- Load and capture alignment (MAC has 2 register stages before accumulate):
  - Issue of element k occurs in cycle c_k.
  - mac_load=1 in cycle c_0+3 only; a single-cycle pulse per job.
  - res_data<=mac_acc sampled in cycle c_last+4; res_valid rises in cycle c_last+5.
  - Implemented as 1-bit first/last shift registers, depth 3 and 4.
- Job latency: start accepted in cycle s gives res_valid in cycle s+len+5 (len>0), s+2 (len=0).
- start while busy=1 is ignored; it is neither queued nor partially latched.
- Result held stable (res_data unchanged, res_valid=1) while res_ready=0.
- Width: len compared at full LEN_WIDTH; address increment truncates to ADDR_WIDTH.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, DRAIN, ZERO, HOLD), localparams MAC_LOAD_DLY=3 and MAC_CAPT_DLY=4.
- Sub-module flag_delay (parameterised depth, 1-bit shift register with synchronous reset), instantiated for the first and last flags.

Test Plan:
- len=1, A[0]=3, B[0]=5 (bench MAC model with DATA_WIDTH=16, scaled slice) -> one rd_en cycle, mac_load 3 cycles after issue, res_data = model(15), res_valid at s+6.
- len=4, A=1,2,3,4, B=5,6,7,8 -> 4 consecutive rd_en cycles, single mac_load pulse, res_data = model(70).
- len=0 -> no rd_en, no mac_load, res_data=0, res_valid at s+2.
- a_base=254, len=4 -> a_addr sequence 254,255,0,1.
- res_ready held 0 for 10 cycles -> res_data stable, busy=1; start pulses ignored; on ready, IDLE next cycle and the next start is accepted.
- reset asserted mid-ISSUE of a len=8 job -> next cycle rd_en=0, res_valid=0, mac_load=0; a following len=2 job produces the correct result.

Source files
------------

// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and MAC alignment constants for the dot-product sequencer.
package dot_product_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ZERO,
        HOLD
    } state_t;

    // The MAC registers operands and then the product before accumulating,
    // so load trails the first issue by 3 cycles and the sum settles 4 after the last.
    localparam int MAC_LOAD_DLY = 3;
    localparam int MAC_CAPT_DLY = 4;

endpackage

// File: rtl/dot_product_sequencer_flag_delay.sv
// Fixed-depth 1-bit delay line; output equals input DEPTH cycles earlier.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module flag_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams operand pairs from two memories into the MAC and captures the dot product.
// Result valid len+5 cycles after start (2 for len=0); result held until res_ready.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_load,
    input  logic [DATA_WIDTH-1:0] mac_acc,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_ready
);

    state_t               state;
    logic [LEN_WIDTH-1:0] rem;
    logic                 first_iss;
    logic                 last_iss;
    logic                 rd_d1;
    logic                 last_dly;

    flag_delay #(.DEPTH(MAC_LOAD_DLY)) u_first_dly (
        .clk   (clk),
        .reset (reset),
        .din   (first_iss),
        .dout  (mac_load)
    );

    flag_delay #(.DEPTH(MAC_CAPT_DLY)) u_last_dly (
        .clk   (clk),
        .reset (reset),
        .din   (last_iss),
        .dout  (last_dly)
    );

    // Read data is only meaningful the cycle after a strobe; zero it otherwise.
    assign mac_a = rd_d1 ? a_rdata : '0;
    assign mac_b = rd_d1 ? b_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_d1     <= 1'b0;
            first_iss <= 1'b0;
            last_iss  <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            rd_d1     <= rd_en;
            first_iss <= 1'b0;
            last_iss  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        a_addr <= a_base;
                        b_addr <= b_base;
                        if (len == '0) begin
                            state <= ZERO;
                        end else begin
                            state     <= ISSUE;
                            rd_en     <= 1'b1;
                            first_iss <= 1'b1;
                            last_iss  <= (len == LEN_WIDTH'(1));
                            rem       <= len - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // rem counts issues still owed after the one now on the bus.
                    if (rem == '0) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        a_addr   <= a_addr + 1'b1;
                        b_addr   <= b_addr + 1'b1;
                        rem      <= rem - 1'b1;
                        last_iss <= (rem == LEN_WIDTH'(1));
                    end
                end
                DRAIN: begin
                    if (last_dly) begin
                        res_data  <= mac_acc;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                ZERO: begin
                    res_data  <= '0;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench: operand memories, a 2-stage load-enabled MAC, and a job-level reference model.
module tb_dot_product_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] a_base = '0;
    logic [AW-1:0] b_base = '0;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_load;
    logic [DW-1:0] mac_acc;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready = 1'b0;

    dot_product_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .a_base    (a_base),
        .b_base    (b_base),
        .busy      (busy),
        .rd_en     (rd_en),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_rdata   (a_rdata),
        .b_rdata   (b_rdata),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_load  (mac_load),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories with registered read.
    logic [DW-1:0] a_mem [256];
    logic [DW-1:0] b_mem [256];
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[a_addr];
            b_rdata <= b_mem[b_addr];
        end
    end

    // MAC: operand register, product register, then accumulate (load restarts the sum).
    logic [DW-1:0] m1a, m1b;
    logic [31:0]   m2, macc;
    always @(posedge clk) begin
        if (reset) begin
            m1a  <= '0;
            m1b  <= '0;
            m2   <= '0;
            macc <= '0;
        end else begin
            m1a  <= mac_a;
            m1b  <= mac_b;
            m2   <= m1a * m1b;
            macc <= mac_load ? m2 : macc + m2;
        end
    end
    assign mac_acc = macc[DW-1:0];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one job record, expectations derived from its start cycle.
    logic          j_act = 1'b0;
    int            j_s = 0;
    int            j_len = 0;
    logic [AW-1:0] j_a = '0;
    logic [AW-1:0] j_b = '0;
    logic [DW-1:0] j_sum = '0;

    always @(negedge clk) begin
        int   t, k, vt;
        logic e_rd, e_ld, e_op, e_val;
        t     = cyc;
        vt    = (j_len == 0) ? j_s + 2 : j_s + j_len + 5;
        e_rd  = j_act && j_len > 0 && t >= j_s + 1 && t <= j_s + j_len;
        e_ld  = j_act && j_len > 0 && t == j_s + 4;
        e_op  = j_act && j_len > 0 && t >= j_s + 2 && t <= j_s + j_len + 1;
        e_val = j_act && t >= vt;
        if (cyc >= 1) begin
            chk("busy", busy, j_act);
            chk("rd_en", rd_en, e_rd);
            chk("mac_load", mac_load, e_ld);
            chk("res_valid", res_valid, e_val);
            if (e_rd) begin
                k = t - j_s - 1;
                chk("a_addr", a_addr, AW'(j_a + k));
                chk("b_addr", b_addr, AW'(j_b + k));
            end
            if (e_op) begin
                k = t - j_s - 2;
                chk("mac_a", mac_a, a_mem[AW'(j_a + k)]);
                chk("mac_b", mac_b, b_mem[AW'(j_b + k)]);
            end else begin
                chk("mac_a_idle", mac_a, 0);
                chk("mac_b_idle", mac_b, 0);
            end
            if (e_val) chk("res_data", res_data, j_sum);
        end
        if (reset) begin
            j_act = 1'b0;
        end else if (!j_act && start) begin
            j_act = 1'b1;
            j_s   = t;
            j_len = int'(len);
            j_a   = a_base;
            j_b   = b_base;
            j_sum = '0;
            for (int i = 0; i < j_len; i++)
                j_sum = j_sum + DW'(a_mem[AW'(j_a + i)] * b_mem[AW'(j_b + i)]);
        end else if (e_val && res_ready) begin
            j_act = 1'b0;
        end
    end

    // Caller sits #1 after an edge; start is raised in the current cycle.
    task automatic do_job(input int l, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input int rdly, output logic [DW-1:0] got, output int lat);
        int s, n;
        start  = 1'b1;
        len    = LW'(l);
        a_base = ab;
        b_base = bb;
        s      = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            start  = ($urandom_range(0, 3) == 0);
            len    = LW'($urandom_range(0, 255));
            a_base = AW'($urandom_range(0, 255));
        end
        if (n >= 200) chk("res_valid_timeout", 1, 0);
        lat = cyc - s;
        got = res_data;
        repeat (rdly) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 1) == 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got;
        int            lat;
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = DW'($urandom);
            b_mem[i] = DW'($urandom);
        end
        a_mem[0] = 16'd3;
        b_mem[0] = 16'd5;
        for (int i = 0; i < 4; i++) begin
            a_mem[16 + i] = DW'(i + 1);
            b_mem[32 + i] = DW'(i + 5);
        end
        a_mem[40] = 16'd7; a_mem[41] = 16'd9;
        b_mem[50] = 16'd2; b_mem[51] = 16'd3;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_a_addr", a_addr, 0);
        chk("reset_b_addr", b_addr, 0);
        chk("reset_res_data", res_data, 0);

        do_job(1, 8'd0, 8'd0, 0, got, lat);
        chk("len1_result", got, 15);
        chk("len1_latency", lat, 6);

        do_job(4, 8'd16, 8'd32, 2, got, lat);
        chk("len4_result", got, 70);
        chk("len4_latency", lat, 9);

        do_job(0, 8'd7, 8'd9, 1, got, lat);
        chk("len0_result", got, 0);
        chk("len0_latency", lat, 2);

        do_job(4, 8'd254, 8'd100, 0, got, lat);
        chk("wrap_latency", lat, 9);

        do_job(3, 8'd60, 8'd70, 10, got, lat);
        chk("hold_latency", lat, 8);

        // Abort a long job mid-issue, just before its load pulse would appear.
        start  = 1'b1;
        len    = 8'd8;
        a_base = 8'd120;
        b_base = 8'd130;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_rd_en", rd_en, 0);
        chk("abort_mac_load", mac_load, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_busy", busy, 0);

        do_job(2, 8'd40, 8'd50, 1, got, lat);
        chk("after_abort_result", got, 41);
        chk("after_abort_latency", lat, 7);

        for (int j = 0; j < 30; j++) begin
            int l;
            l = $urandom_range(0, 20);
            do_job(l, AW'($urandom), AW'($urandom), $urandom_range(0, 4), got, lat);
            chk("rand_latency", lat, (l == 0) ? 2 : l + 5);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
